// File: rtl/line_window3x3_if.sv
// Pixel-stream in / 3x3 window out bundle for line_window3x3.
// LINE_WINDOW3X3_WINCNT_EN adds the win_count debug readback signal.
interface line_window3x3_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pixel_in;
    logic              pixel_valid;
    logic              frame_start;
    logic [DATA_W-1:0] lb_ready0, lb_ready1, lb_ready2;
    logic [DATA_W-1:0] lb_ready3, lb_ready4, lb_ready5;
    logic [DATA_W-1:0] lb_ready6, lb_ready7, lb_ready8;
    logic              result_rdy;
    logic              pixel_end;
`ifdef LINE_WINDOW3X3_WINCNT_EN
    logic [15:0]       win_count;

    modport master (
        output pixel_in, pixel_valid, frame_start,
        input  lb_ready0, lb_ready1, lb_ready2, lb_ready3, lb_ready4,
               lb_ready5, lb_ready6, lb_ready7, lb_ready8,
               result_rdy, pixel_end, win_count
    );
    modport slave (
        input  pixel_in, pixel_valid, frame_start,
        output lb_ready0, lb_ready1, lb_ready2, lb_ready3, lb_ready4,
               lb_ready5, lb_ready6, lb_ready7, lb_ready8,
               result_rdy, pixel_end, win_count
    );
`else
    modport master (
        output pixel_in, pixel_valid, frame_start,
        input  lb_ready0, lb_ready1, lb_ready2, lb_ready3, lb_ready4,
               lb_ready5, lb_ready6, lb_ready7, lb_ready8,
               result_rdy, pixel_end
    );
    modport slave (
        input  pixel_in, pixel_valid, frame_start,
        output lb_ready0, lb_ready1, lb_ready2, lb_ready3, lb_ready4,
               lb_ready5, lb_ready6, lb_ready7, lb_ready8,
               result_rdy, pixel_end
    );
`endif
endinterface

// File: rtl/line_window3x3.sv
// Two-line buffer and sliding 3x3 window over a raster pixel stream (valid-mode, no padding).
// Optional macro LINE_WINDOW3X3_WINCNT_EN adds a per-frame window counter on bus.win_count.
module line_window3x3 #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int DATA_W     = 8
) (
    input logic               clk,
    input logic               rst_n,
    line_window3x3_if.slave   bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [CW-1:0]     col, cur_col, col_next;
    logic [RW-1:0]     row, cur_row, row_next;
    logic [0:0]        state, cur_state, state_next;
    logic              accept, restart, last_col, last_row, win_valid, frame_last;
    logic              result_q, end_q;
    logic [DATA_W-1:0] line0 [IMG_WIDTH];
    logic [DATA_W-1:0] line1 [IMG_WIDTH];
    logic [DATA_W-1:0] win      [3][3];
    logic [DATA_W-1:0] win_next [3][3];
    logic [DATA_W-1:0] taps [9];

    // A frame_start pixel is treated as if the counters already sat at (0,0) in S_FILL.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accept     = bus.pixel_valid;
        restart    = accept && bus.frame_start;
        cur_col    = restart ? '0 : col;
        cur_row    = restart ? '0 : row;
        cur_state  = restart ? S_FILL : state;
        last_col   = (cur_col == CW'(IMG_WIDTH - 1));
        last_row   = (cur_row == RW'(IMG_HEIGHT - 1));
        win_valid  = accept && (cur_state == S_RUN) && (cur_col >= CW'(2));
        frame_last = win_valid && last_row && last_col;
        col_next   = last_col ? '0 : cur_col + CW'(1);
        row_next   = cur_row;
        state_next = cur_state;
        if (last_col) begin
            row_next = last_row ? '0 : cur_row + RW'(1);
            if (cur_row == RW'(1))
                state_next = S_RUN;
            else if (last_row)
                state_next = S_FILL;
        end
        for (int r = 0; r < 3; r++) begin
            win_next[r][0] = win[r][1];
            win_next[r][1] = win[r][2];
        end
        win_next[0][2] = line1[cur_col];
        win_next[1][2] = line0[cur_col];
        win_next[2][2] = bus.pixel_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            state <= S_FILL;
        end else if (accept) begin
            col   <= col_next;
            row   <= row_next;
            state <= state_next;
        end
    end

    // Read-before-write: the window already captured line0/line1[cur_col] combinationally.
    always_ff @(posedge clk) begin
        // NOTE: line RAMs carry no reset; the two fill rows overwrite them before any window uses them.
        if (accept) begin
            line1[cur_col] <= line0[cur_col];
            line0[cur_col] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 1'b0;
            end_q    <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            for (int i = 0; i < 9; i++)
                taps[i] <= '0;
        end else begin
            result_q <= win_valid;
            end_q    <= frame_last;
            if (accept)
                win <= win_next;
            if (win_valid)
                for (int i = 0; i < 9; i++)
                    taps[i] <= win_next[i / 3][i % 3];
        end
    end

`ifdef LINE_WINDOW3X3_WINCNT_EN
    logic [15:0] win_count;

    // Holds the full frame total during the pixel_end cycle, then clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            win_count <= '0;
        else if (restart || end_q)
            win_count <= '0;
        else if (win_valid)
            win_count <= win_count + 16'd1;
    end

    assign bus.win_count = win_count;
`endif

    assign bus.result_rdy = result_q;
    assign bus.pixel_end  = end_q;
    assign bus.lb_ready0  = taps[0];
    assign bus.lb_ready1  = taps[1];
    assign bus.lb_ready2  = taps[2];
    assign bus.lb_ready3  = taps[3];
    assign bus.lb_ready4  = taps[4];
    assign bus.lb_ready5  = taps[5];
    assign bus.lb_ready6  = taps[6];
    assign bus.lb_ready7  = taps[7];
    assign bus.lb_ready8  = taps[8];
endmodule

// File: tb/tb_line_window3x3.sv
// Self-checking bench for line_window3x3 on a 4x4 image: image-array model plus literal windows.
// Exercises win_count too when built with LINE_WINDOW3X3_WINCNT_EN.
module tb_line_window3x3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_window3x3_if #(.DATA_W(DW)) bus ();

    line_window3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function logic [71:0] dut_taps();
        return {bus.lb_ready0, bus.lb_ready1, bus.lb_ready2, bus.lb_ready3, bus.lb_ready4,
                bus.lb_ready5, bus.lb_ready6, bus.lb_ready7, bus.lb_ready8};
    endfunction

    // Hand-computed windows of the 1..16 image, in emission order.
    logic [71:0] ref_win [4] = '{
        {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11},
        {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12},
        {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15},
        {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16}
    };
    logic [71:0] win_101 = {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111};
    logic [71:0] win_201 = {8'd201, 8'd202, 8'd203, 8'd205, 8'd206, 8'd207, 8'd209, 8'd210, 8'd211};

    // Model: place each accepted pixel into an image by raster position, cut windows from it.
    int          mr = 0, mc = 0;
    logic [7:0]  img [H][W];
    logic        exp_rdy = 1'b0, exp_end = 1'b0, prev_acc = 1'b0;
    logic [71:0] exp_taps = '0;
    logic [15:0] exp_wc = '0;

    task automatic model_step();
        logic was_end;
        if (!rst_n) begin
            mr = 0; mc = 0; exp_rdy = 0; exp_end = 0; exp_taps = '0; prev_acc = 0; exp_wc = '0;
            return;
        end
        was_end  = exp_end;
        prev_acc = bus.pixel_valid;
        exp_rdy  = 1'b0;
        exp_end  = 1'b0;
        if (was_end) exp_wc = '0;
        if (bus.pixel_valid) begin
            if (bus.frame_start) begin
                mr = 0; mc = 0; exp_wc = '0;
            end
            img[mr][mc] = bus.pixel_in;
            if (mr >= 2 && mc >= 2) begin
                exp_rdy  = 1'b1;
                exp_end  = (mr == H - 1) && (mc == W - 1);
                exp_taps = '0;
                for (int i = 0; i < 9; i++)
                    exp_taps = {exp_taps[63:0], img[mr - 2 + i / 3][mc - 2 + i % 3]};
                exp_wc++;
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr + 1) % H;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-test log of what the DUT emitted, used by the literal checks.
    int          n_strobe = 0, n_end = 0;
    logic [71:0] win_log [$];
    logic [15:0] wc_log [$];
    logic [15:0] wc_at_end = '0;

    initial forever begin
        @(negedge clk);
        check("result_rdy", bus.result_rdy, exp_rdy);
        check("pixel_end", bus.pixel_end, exp_end);
        check("taps", dut_taps(), exp_taps);
        if (!prev_acc)
            check("rdy_after_gap", bus.result_rdy, 1'b0);
`ifdef LINE_WINDOW3X3_WINCNT_EN
        check("win_count", bus.win_count, exp_wc);
`endif
        if (bus.result_rdy) begin
            n_strobe++;
            win_log.push_back(dut_taps());
`ifdef LINE_WINDOW3X3_WINCNT_EN
            wc_log.push_back(bus.win_count);
            if (bus.pixel_end) wc_at_end = bus.win_count;
`endif
            if (bus.pixel_end) n_end++;
        end
    end

    task automatic send(input logic [7:0] p, input logic fs);
        @(negedge clk);
        bus.pixel_in    = p;
        bus.pixel_valid = 1'b1;
        bus.frame_start = fs;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pixel_valid = 1'b0;
            bus.frame_start = 1'b0;
        end
    endtask

    task automatic clear_log();
        #1;
        n_strobe = 0;
        n_end    = 0;
        win_log.delete();
        wc_log.delete();
    endtask

    task automatic check_ref_frame(input string tag);
        check({tag, "_strobes"}, n_strobe, 4);
        check({tag, "_ends"}, n_end, 1);
        for (int i = 0; i < 4; i++)
            check({tag, "_win"}, win_log[i], ref_win[i]);
    endtask

    int gaps [16] = '{2, 0, 1, 3, 0, 0, 2, 1, 0, 1, 0, 2, 0, 1, 1, 0};

    initial begin
        bus.pixel_in    = '0;
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        #2;
        check("reset_rdy", bus.result_rdy, 1'b0);
        check("reset_end", bus.pixel_end, 1'b0);
        check("reset_taps", dut_taps(), 72'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame from reset.
        clear_log();
        for (int p = 1; p <= 16; p++) send(8'(p), 1'b0);
        idle(2);
        check_ref_frame("cont");
`ifdef LINE_WINDOW3X3_WINCNT_EN
        for (int i = 0; i < 4; i++)
            check("wc_seq", wc_log[i], 16'(i + 1));
        check("wc_at_end", wc_at_end, 16'd4);
        check("wc_cleared", bus.win_count, 16'd0);
`endif

        // Same frame with gaps, plus a frame_start pulse that arrives without pixel_valid.
        clear_log();
        for (int p = 1; p <= 16; p++) begin
            send(8'(p), 1'b0);
            if (p == 3) begin
                @(negedge clk);
                bus.pixel_valid = 1'b0;
                bus.frame_start = 1'b1;
            end
            idle(gaps[p - 1]);
        end
        idle(2);
        check_ref_frame("gaps");

        // Back-to-back frames, frame_start on the natural (0,0) pixel.
        clear_log();
        for (int p = 1; p <= 16; p++) send(8'(p), p == 1);
        for (int p = 101; p <= 116; p++) send(8'(p), 1'b0);
        idle(2);
        check("b2b_strobes", n_strobe, 8);
        check("b2b_ends", n_end, 2);
        check("b2b_first", win_log[0], ref_win[0]);
        check("b2b_second", win_log[4], win_101);

        // Frame abandoned by frame_start on its 7th pixel.
        clear_log();
        for (int p = 1; p <= 6; p++) send(8'(p), 1'b0);
        for (int p = 201; p <= 216; p++) send(8'(p), p == 201);
        idle(2);
        check("abandon_strobes", n_strobe, 4);
        check("abandon_ends", n_end, 1);
        check("abandon_first", win_log[0], win_201);

        // Asynchronous reset mid-cycle after pixel 10, then replay.
        clear_log();
        for (int p = 1; p <= 10; p++) send(8'(p), 1'b0);
        @(posedge clk);
        #3;
        rst_n           = 1'b0;
        bus.pixel_valid = 1'b0;
        #1;
        check("arst_rdy", bus.result_rdy, 1'b0);
        check("arst_end", bus.pixel_end, 1'b0);
        check("arst_taps", dut_taps(), 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        for (int p = 1; p <= 16; p++) send(8'(p), 1'b0);
        idle(2);
        check_ref_frame("replay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
